// File: rtl/bcd_display_converter_pkg.sv
// Shared types and constants for the binary-to-BCD display converter.
// Holds the digit type, FSM state encoding and the shift-and-add-3 constants.
package display_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } conv_state_t;

  localparam bcd_t BCD_ADJ_THRESH = 4'd5;
  localparam bcd_t BCD_ADJ        = 4'd3;

  // Used at elaboration to confirm DIGITS decimal digits can hold any BIN_W-bit value.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_display_converter_if.sv
// Valid/ready input and registered display outputs of the BCD converter.
// The upstream producer uses the master modport, the converter uses slave.
interface bcd_display_converter_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 8
);

  logic                  in_valid;
  logic [BIN_W-1:0]      in_data;
  logic                  in_ready;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;

  modport master (
    output in_valid, in_data,
    input  in_ready, done, bcd, blank
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, done, bcd, blank
  );

endinterface

// File: rtl/bcd_display_converter_adjust.sv
// One BCD digit of the shift-and-add-3 step: digits of 5 or more get +3
// so the following left shift carries correctly into the next decade.
module bcd_digit_adjust
  import display_pkg::*;
(
  input  bcd_t d,
  output bcd_t q
);

  assign q = (d >= BCD_ADJ_THRESH) ? bcd_t'(d + BCD_ADJ) : d;

endmodule

// File: rtl/bcd_display_converter.sv
// Sequential binary-to-BCD converter feeding the seven-segment display path.
// Optional leading-zero blanking is built when BCD_LEADING_ZERO_BLANK_EN is defined.
module bcd_display_converter
  import display_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 8
) (
  input  logic                    clock,
  input  logic                    reset_l,
  bcd_display_converter_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  if (pow10(DIGITS) <= (64'd1 << BIN_W)) begin : g_digits_check
    $error("bcd_display_converter: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  conv_state_t         state_q, state_d;
  cnt_t                count_q;
  logic [BIN_W-1:0]    bin_q, bin_shift;
  logic [4*DIGITS-1:0] work_q, work_adj, work_shift;
  logic [4*DIGITS-1:0] bcd_q;
  logic                accept;
  logic                last_shift;

  assign bus.in_ready = (state_q == IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.bcd      = bcd_q;

  assign accept     = bus.in_valid && (state_q == IDLE);
  assign last_shift = (state_q == CONVERT) && (count_q == cnt_t'(1));

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) state_q <= IDLE;
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: next state defaults to hold so no path through the case leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = CONVERT;
      CONVERT: if (count_q == cnt_t'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d(work_q[4*i +: 4]),
      .q(work_adj[4*i +: 4])
    );
  end

  // Adjusted digits and remaining binary bits shift as one register; bin MSB enters digit0.
  assign {work_shift, bin_shift} = {work_adj, bin_q} << 1;

  // NOTE: working registers are reset too, so an aborted conversion leaves nothing behind.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      bin_q   <= '0;
      work_q  <= '0;
      count_q <= '0;
      bcd_q   <= '0;
    end else if (accept) begin
      bin_q   <= bus.in_data;
      work_q  <= '0;
      count_q <= cnt_t'(BIN_W);
    end else if (state_q == CONVERT) begin
      bin_q   <= bin_shift;
      work_q  <= work_shift;
      count_q <= count_q - cnt_t'(1);
      if (last_shift) bcd_q <= work_shift;
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;

  // Digit i blanks when it and every more significant digit are zero; digit0 always shows.
  always_comb begin : blank_calc
    logic upper_nz;
    upper_nz = 1'b0;
    blank_d  = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_nz   = upper_nz | (work_shift[4*i +: 4] != 4'd0);
      blank_d[i] = ~upper_nz;
    end
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l)        blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    else if (last_shift) blank_q <= blank_d;
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

endmodule

// File: tb/tb_bcd_display_converter.sv
// Directed bench for bcd_display_converter: reset, boundaries, back-to-back,
// abort by reset, busy-input isolation and a strided sweep against a decimal model.
module tb_bcd_display_converter;

  logic clock   = 1'b0;
  logic reset_l = 1'b0;

  always #5 clock = ~clock;

  bcd_display_converter_if #(.BIN_W(16), .DIGITS(8)) bus ();

  bcd_display_converter #(.BIN_W(16), .DIGITS(8)) dut (
    .clock  (clock),
    .reset_l(reset_l),
    .bus    (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] shown_bcd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected blank for the current build: the enabled value, or all-shown.
  function automatic logic [7:0] exp_blank(input logic [7:0] en_val);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    return en_val;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [31:0] dec_model(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] blank_model(input logic [31:0] d);
    logic [7:0] r;
    logic       nz;
    r  = '0;
    nz = 1'b0;
    for (int i = 7; i > 0; i--) begin
      nz   = nz | (d[4*i +: 4] != 4'd0);
      r[i] = !nz;
    end
    return exp_blank(r);
  endfunction

  // Called at a negedge. mode 0: valid dropped after accept; 1: random data with
  // valid high while busy; 2: next_val presented and held through completion.
  task automatic convert(input string tag, input logic [15:0] val, input logic [31:0] exp_bcd,
                         input logic [7:0] exp_blk, input int mode, input logic [15:0] next_val);
    int waited = 0;
    int low    = 0;
    int pulses = 0;
    int cyc    = 0;
    bit seen_done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = val;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check({tag, " accept"}, 64'(bus.in_ready), 64'd1);
    @(negedge clock);
    case (mode)
      1:       begin bus.in_valid = 1'b1; bus.in_data = 16'($urandom); end
      2:       begin bus.in_valid = 1'b1; bus.in_data = next_val; end
      default: begin bus.in_valid = 1'b0; bus.in_data = ~val; end
    endcase
    while (cyc < 40) begin
      cyc++;
      if (!bus.in_ready) low++;
      if (cyc == 8) check({tag, " hold"}, 64'(bus.bcd), 64'(shown_bcd));
      if (bus.done) begin
        pulses++;
        seen_done = 1'b1;
        check({tag, " bcd"}, 64'(bus.bcd), 64'(exp_bcd));
        check({tag, " blank"}, 64'(bus.blank), 64'(exp_blk));
        if (mode != 2) bus.in_valid = 1'b0;
      end else if (seen_done) begin
        break;
      end
      @(negedge clock);
      if (mode == 1 && !seen_done) bus.in_data = 16'($urandom);
    end
    check({tag, " done_pulses"}, 64'(pulses), 64'd1);
    check({tag, " busy_cycles"}, 64'(low), 64'd17);
    check({tag, " ready_after"}, 64'(bus.in_ready), 64'd1);
    shown_bcd = exp_bcd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [15:0] sweep_vals[$];

    // Reset, with in_valid asserted to show it is ignored while in reset.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd1234;
    reset_l      = 1'b0;
    repeat (3) @(negedge clock);
    check("rst bcd", 64'(bus.bcd), 64'h0);
    check("rst done", 64'(bus.done), 64'h0);
    check("rst blank", 64'(bus.blank), 64'(exp_blank(8'hFE)));
    bus.in_valid = 1'b0;
    reset_l      = 1'b1;
    @(negedge clock);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst no_done", 64'(bus.done), 64'd0);

    convert("zero", 16'd0, 32'h0000_0000, exp_blank(8'hFE), 0, 16'd0);
    convert("max", 16'd65535, 32'h0006_5535, exp_blank(8'hE0), 1, 16'd0);

    // Back-to-back: 9 is held valid through the 1234 conversion.
    convert("b2b_1234", 16'd1234, 32'h0000_1234, exp_blank(8'hF0), 2, 16'd9);
    convert("b2b_9", 16'd9, 32'h0000_0009, exp_blank(8'hFE), 0, 16'd0);

    // Abort by reset in the 8th CONVERT cycle of 4321.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd4321;
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clock);
    reset_l = 1'b0;
    #1;
    check("abort bcd", 64'(bus.bcd), 64'h0);
    check("abort done", 64'(bus.done), 64'h0);
    check("abort blank", 64'(bus.blank), 64'(exp_blank(8'hFE)));
    @(negedge clock);
    reset_l = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.done) pulses++;
    end
    check("abort no_pulse", 64'(pulses), 64'd0);
    check("abort idle", 64'(bus.in_ready), 64'd1);
    shown_bcd = '0;
    convert("after_abort", 16'd77, 32'h0000_0077, exp_blank(8'hFC), 0, 16'd0);

    // Decade boundaries plus a strided sweep, busy inputs randomised.
    sweep_vals = '{16'd1, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000,
                   16'd9999, 16'd10000, 16'd59999, 16'd65534};
    for (int v = 0; v < 65536; v += 331) sweep_vals.push_back(16'(v));
    foreach (sweep_vals[i]) begin
      convert($sformatf("sweep_%0d", sweep_vals[i]), sweep_vals[i],
              dec_model(int'(sweep_vals[i])), blank_model(dec_model(int'(sweep_vals[i]))),
              i % 2, 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
